// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Takes a byte stream of the form LEN[7:0], LEN[15:8], then LEN little-endian
// 32-bit words. Each word is written to instruction SRAM in a one-cycle WRITE
// state. The core is held in reset until the whole image has been written.
// An oversize length or a stalled stream parks the loader in ERR.
//
// state    | meaning
// ---------+------------------------------------------------------------
// LEN_LO   | waiting for length low byte (no timeout)
// LEN_HI   | waiting for length high byte; decides DONE / ERR / DATA
// DATA     | collecting bytes 0..3 of the current word
// WRITE    | single-cycle SRAM write of the assembled word
// DONE     | image complete, core released; terminal until reset
// ERR      | aborted load, core stays in reset; terminal until reset
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  im_w_en,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err,
  output logic [14:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  // Idle counter value at which the next idle cycle reaches TIMEOUT.
  localparam logic [20:0] TMO_LAST = TMO_EN ? 21'(TIMEOUT - 1) : 21'd0;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [20:0] tmo_q, tmo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [14:0] wl_q, wl_d;
  logic        ready_q, ready_d;
  logic [3:0]  wen_q, wen_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        core_rst_q, core_rst_d;

  logic        hs;
  logic [15:0] len_full;
  logic [14:0] wl_inc;
  logic        tmo_hit;
  logic [20:0] tmo_inc;

  // Next-state logic, datapath updates and registered-output precompute.
  always_comb begin
    hs       = in_valid & ready_q;
    len_full = {in_data, len_q[7:0]};
    wl_inc   = wl_q + 15'd1;
    tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);
    tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + 21'd1;

    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    wl_d    = wl_q;

    case (state_q)
      S_LEN_LO: begin
        if (hs) begin
          len_d[7:0] = in_data;
          tmo_d      = '0;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          len_d = len_full;
          tmo_d = '0;
          idx_d = '0;
          if (len_full == 16'd0)            state_d = S_DONE;
          else if ({1'b0, len_full} > MAX_W) state_d = S_ERR;
          else                               state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_DATA: begin
        if (hs) begin
          case (idx_q)
            2'd0:    wdata_d[7:0]   = in_data;
            2'd1:    wdata_d[15:8]  = in_data;
            2'd2:    wdata_d[23:16] = in_data;
            default: wdata_d[31:24] = in_data;
          endcase
          idx_d = idx_q + 2'd1;
          tmo_d = '0;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_WRITE: begin
        // The SRAM captures the word on the edge that leaves this state.
        wl_d   = wl_inc;
        addr_d = addr_q + 16'd4;
        tmo_d  = '0;
        state_d = ({1'b0, wl_inc} == len_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    ready_d    = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    wen_d      = (state_d == S_WRITE) ? 4'b1111 : 4'b0000;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN_LO;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      wl_q       <= '0;
      ready_q    <= 1'b0;
      wen_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wl_q       <= wl_d;
      ready_q    <= ready_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign in_ready     = ready_q;
  assign im_w_en      = wen_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances share one stream, one at base
// 0x0000 and one at base 0x0100, both with a short idle timeout of 10 cycles.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        rdy_a, rdy_b;
  logic [3:0]  wen_a, wen_b;
  logic [15:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        crst_a, crst_b;
  logic        done_a, done_b;
  logic        err_a, err_b;
  logic [14:0] wl_a, wl_b;

  imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16384), .TIMEOUT(10)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .im_w_en(wen_a), .im_addr(addr_a), .im_wdata(wdata_a),
    .core_rst(crst_a), .done(done_a), .err(err_a), .words_loaded(wl_a)
  );

  imem_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(16384), .TIMEOUT(10)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .im_w_en(wen_b), .im_addr(addr_b), .im_wdata(wdata_b),
    .core_rst(crst_b), .done(done_b), .err(err_b), .words_loaded(wl_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [51:0] qa[$];
  logic [51:0] qb[$];
  logic [31:0] exp_w [8];

  bit watch_b = 1'b0;
  int ready_low_b = 0;
  int viol_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record every SRAM write cycle (enable, address, data) for both instances.
  always @(negedge clk) begin
    if (rst && wen_a != 4'h0) qa.push_back({wen_a, addr_a, wdata_a});
    if (rst && wen_b != 4'h0) qb.push_back({wen_b, addr_b, wdata_b});
    if (watch_b && !done_b && !err_b) begin
      if (!rdy_b) ready_low_b++;
      if ((wen_b == 4'hF) == rdy_b) viol_b++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    qa.delete(); qb.delete();
    chk("rst_ready", {31'b0, rdy_a}, 32'd0);
    chk("rst_wen", {28'b0, wen_a}, 32'd0);
    chk("rst_addr_a", {16'b0, addr_a}, 32'h0000);
    chk("rst_addr_b", {16'b0, addr_b}, 32'h0100);
    chk("rst_wdata", wdata_a, 32'd0);
    chk("rst_core_rst", {31'b0, crst_a}, 32'd1);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    chk("rst_wl", {17'b0, wl_a}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Idle for gap cycles, then present b until it is accepted. Returns on the
  // falling edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!rdy_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_a) chk("hs_wait", {31'b0, rdy_a}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic check_wr(input string pfx, input bit use_b, input logic [15:0] base, input int n);
    logic [51:0] e;
    int sz;
    sz = use_b ? qb.size() : qa.size();
    chk({pfx, "_wr_count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) begin
        e = use_b ? qb[i] : qa[i];
        chk($sformatf("%s_wr%0d_en", pfx, i), {28'b0, e[51:48]}, 32'hF);
        chk($sformatf("%s_wr%0d_addr", pfx, i), {16'b0, e[47:32]}, {16'b0, base + 16'(4 * i)});
        chk($sformatf("%s_wr%0d_data", pfx, i), e[31:0], exp_w[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // 1: two-word image
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0);
    send_word(32'h00100093, 0);
    chk("t1_write_wen", {28'b0, wen_a}, 32'hF);
    chk("t1_write_done", {31'b0, done_a}, 32'd0);
    chk("t1_write_crst", {31'b0, crst_a}, 32'd1);
    chk("t1_write_ready", {31'b0, rdy_a}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'b0, done_a}, 32'd1);
    chk("t1_crst", {31'b0, crst_a}, 32'd0);
    chk("t1_wl", {17'b0, wl_a}, 32'd2);
    chk("t1_addr_next", {16'b0, addr_a}, 32'h0008);
    chk("t1_wen_after", {28'b0, wen_a}, 32'd0);
    exp_w[0] = 32'h00000013; exp_w[1] = 32'h00100093;
    check_wr("t1a", 1'b0, 16'h0000, 2);
    check_wr("t1b", 1'b1, 16'h0100, 2);
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t1_ign_ready", {31'b0, rdy_a}, 32'd0);
    chk("t1_ign_wl", {17'b0, wl_a}, 32'd2);
    chk("t1_ign_writes", qa.size(), 32'd2);
    chk("t1_ign_done", {31'b0, done_a}, 32'd1);

    // 2: empty image
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("t2_done", {31'b0, done_a}, 32'd1);
    chk("t2_crst", {31'b0, crst_a}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t2_writes", qa.size(), 32'd0);
    chk("t2_wl", {17'b0, wl_a}, 32'd0);

    // 3: oversize length, then the largest legal length
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h40, 0);
    chk("t3_err", {31'b0, err_a}, 32'd1);
    chk("t3_crst", {31'b0, crst_a}, 32'd1);
    chk("t3_done", {31'b0, done_a}, 32'd0);
    chk("t3_ready", {31'b0, rdy_a}, 32'd0);
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h40, 0);
    chk("t3_max_err", {31'b0, err_a}, 32'd0);
    chk("t3_max_ready", {31'b0, rdy_a}, 32'd1);

    // 4: stall mid-word
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (9) @(negedge clk);
    chk("t4_err_early", {31'b0, err_a}, 32'd0);
    @(negedge clk);
    chk("t4_err", {31'b0, err_a}, 32'd1);
    chk("t4_crst", {31'b0, crst_a}, 32'd1);
    chk("t4_ready", {31'b0, rdy_a}, 32'd0);
    chk("t4_writes", qa.size(), 32'd0);

    // 5: eight words with idle gaps, checked on the 0x0100 instance
    exp_w = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h003100B3,
              32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h80000001};
    do_reset();
    ready_low_b = 0; viol_b = 0; watch_b = 1'b1;
    send_byte(8'h08, 3); send_byte(8'h00, 5);
    for (int i = 0; i < 8; i++) begin
      send_byte(exp_w[i][7:0],   (i * 3) % 6);
      send_byte(exp_w[i][15:8],  (i * 3 + 1) % 6);
      send_byte(exp_w[i][23:16], (i * 3 + 2) % 6);
      send_byte(exp_w[i][31:24], (i * 5 + 3) % 6);
    end
    @(negedge clk);
    watch_b = 1'b0;
    chk("t5_done", {31'b0, done_b}, 32'd1);
    chk("t5_wl", {17'b0, wl_b}, 32'd8);
    chk("t5_ready_low", ready_low_b, 32'd8);
    chk("t5_ready_viol", viol_b, 32'd0);
    check_wr("t5", 1'b1, 16'h0100, 8);

    // 6: reset mid-load, then a clean reload
    do_reset();
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 1);
    send_byte(8'h33, 0); send_byte(8'h33, 0);
    chk("t6_wl_before", {17'b0, wl_a}, 32'd2);
    do_reset();
    exp_w[0] = 32'hA0A0A0A1; exp_w[1] = 32'hB0B0B0B2;
    exp_w[2] = 32'hC0C0C0C3; exp_w[3] = 32'hD0D0D0D4;
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_word(exp_w[i], i % 2);
    @(negedge clk);
    chk("t6_done", {31'b0, done_a}, 32'd1);
    chk("t6_wl", {17'b0, wl_a}, 32'd4);
    check_wr("t6", 1'b0, 16'h0000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
